// File: rtl/countdown_pkg.sv
// Shared constants for the countdown timer: FSM state encoding and
// default parameter values used by the top and its prescaler.
package countdown_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  // Parameter defaults
  localparam int PRESCALE_W_DEFAULT = 26;
  localparam int CNT_W_DEFAULT      = 4;

endpackage

// File: rtl/countdown_timer_prescaler.sv
// Free-running prescaler for the countdown timer. Counts enabled clocks
// modulo 2**WIDTH and flags the edge on which it wraps back to zero.
module clk_prescaler
  import countdown_pkg::*;
#(
  parameter int WIDTH = PRESCALE_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  logic [WIDTH-1:0] count_reg;

  // The wrap strobe marks the edge on which the all-ones value rolls over,
  // i.e. the edge on which the owner should take a step.
  assign wrap = enable && (count_reg == {WIDTH{1'b1}});

  // Modular count of enabled clocks; clear restarts the period from zero.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, one-cycle step/terminal pulses,
// held done flag and optional auto-reload for periodic operation.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             auto_reload,
  output logic [CNT_W-1:0] counter_out,
  output logic             step,
  output logic             terminal,
  output logic             done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_reg,  state_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic [CNT_W-1:0] reload_reg, reload_next;
  logic             step_reg,   step_next;
  logic             term_reg,   term_next;
  logic             done_reg;
  logic             busy_reg;
  logic             presc_en;
  logic             presc_wrap;

  // The prescaler only advances while actually running; a load restarts
  // the period so the first step lands a full period after the load.
  assign presc_en = (state_reg == ST_RUN) && enable && !load;

  clk_prescaler #(
    .WIDTH (PRESCALE_W)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (load),
    .enable (presc_en),
    .wrap   (presc_wrap)
  );

  // Next-state logic: load beats stepping; stepping only on a prescaler wrap.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    step_next   = 1'b0;
    term_next   = 1'b0;
    if (load) begin
      count_next  = load_value;
      reload_next = load_value;
      state_next  = (load_value != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (presc_wrap) begin
            step_next = 1'b1;
            if (count_reg == CNT_ONE) begin
              term_next = 1'b1;
              if (auto_reload) begin
                count_next = reload_reg;
              end else begin
                count_next = '0;
                state_next = ST_EXPIRED;
              end
            end else if (count_reg != '0) begin
              count_next = count_reg - CNT_ONE;
            end
          end
        end
        ST_IDLE, ST_EXPIRED: begin
          // Held until load or reset.
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; done/busy are registered from the next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      step_reg   <= 1'b0;
      term_reg   <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      step_reg   <= step_next;
      term_reg   <= term_next;
      done_reg   <= (state_next == ST_EXPIRED);
      busy_reg   <= (state_next == ST_RUN);
    end
  end

  assign counter_out = count_reg;
  assign step        = step_reg;
  assign terminal    = term_reg;
  assign done        = done_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (PRESCALE_W=2, CNT_W=4): directed
// scenarios with hand-derived expectations, then randomized stimulus checked
// every cycle against a behavioural reference model.
module tb_countdown_timer;

  localparam int PW     = 2;
  localparam int CW     = 4;
  localparam int PERIOD = 1 << PW;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          load;
  logic [CW-1:0] load_value;
  logic          auto_reload;
  logic [CW-1:0] counter_out;
  logic          step;
  logic          terminal;
  logic          done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: remaining count, enabled edges into current period.
  int m_count, m_reload, m_phase;
  bit m_running, m_expired, m_step, m_term;

  countdown_timer #(
    .PRESCALE_W (PW),
    .CNT_W      (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .counter_out (counter_out),
    .step        (step),
    .terminal    (terminal),
    .done        (done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: a timer holds "remaining ticks" and counts enabled
  // edges; every PERIOD enabled edges one tick elapses.
  task automatic model_edge();
    if (reset) begin
      m_count = 0; m_reload = 0; m_phase = 0;
      m_running = 0; m_expired = 0; m_step = 0; m_term = 0;
    end else if (load) begin
      m_count = int'(load_value); m_reload = int'(load_value); m_phase = 0;
      m_running = (load_value != 0); m_expired = 0; m_step = 0; m_term = 0;
    end else begin
      m_step = 0; m_term = 0;
      if (m_running && enable) begin
        m_phase = m_phase + 1;
        if (m_phase == PERIOD) begin
          m_phase = 0;
          m_step  = 1;
          if (m_count == 1) begin
            m_term = 1;
            if (auto_reload) m_count = m_reload;
            else begin
              m_count = 0; m_running = 0; m_expired = 1;
            end
          end else begin
            m_count = m_count - 1;
          end
        end
      end
    end
  endtask

  // One clock edge: model follows the inputs held across the edge, then
  // outputs are compared 1 time unit later.
  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_value("count",    32'(counter_out), 32'(m_count));
    check_value("step",     32'(step),        32'(m_step));
    check_value("terminal", 32'(terminal),    32'(m_term));
    check_value("done",     32'(done),        32'(m_expired));
    check_value("busy",     32'(busy),        32'(m_running));
  endtask

  task automatic do_load(input int v, input bit ar);
    load = 1'b1; load_value = CW'(v); auto_reload = ar;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_value = '0; auto_reload = 1'b0;
    cycle(); cycle();
    check_value("rst_count", 32'(counter_out), 0);
    check_value("rst_busy",  32'(busy), 0);
    reset = 1'b0;

    // 1: reset held 3 cycles mid-run, then stays idle with enable high.
    enable = 1'b1;
    do_load(5, 1'b0);
    for (int e = 1; e <= 5; e++) cycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_value("t1_count", 32'(counter_out), 0);
      check_value("t1_flags", {28'd0, step, terminal, done, busy}, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_value("t1_idle_count", 32'(counter_out), 0);
      check_value("t1_idle_busy",  32'(busy), 0);
    end

    // 2: load 3, one-shot expiry at edge 12.
    do_load(3, 1'b0);
    for (int e = 1; e <= 16; e++) begin
      cycle();
      check_value("t2_count", 32'(counter_out), (e < 4) ? 3 : (e < 8) ? 2 : (e < 12) ? 1 : 0);
      check_value("t2_term",  32'(terminal), 32'(e == 12));
      check_value("t2_done",  32'(done), 32'(e >= 12));
      check_value("t2_busy",  32'(busy), 32'(e < 12));
    end

    // 3: load 2 with auto-reload, periodic 2,1,2,1...
    do_load(2, 1'b1);
    for (int e = 1; e <= 17; e++) begin
      cycle();
      check_value("t3_count", 32'(counter_out), ((e / 4) % 2 == 0) ? 2 : 1);
      check_value("t3_term",  32'(terminal), 32'((e % 4 == 0) && ((e / 4) % 2 == 0)));
      check_value("t3_busy",  32'(busy), 1);
    end
    auto_reload = 1'b0;

    // 4: load 5, enable dropped for edges 2..9; first step at edge 12.
    do_load(5, 1'b0);
    for (int e = 1; e <= 13; e++) begin
      enable = !(e >= 2 && e <= 9);
      cycle();
      check_value("t4_count", 32'(counter_out), (e < 12) ? 5 : 4);
      check_value("t4_step",  32'(step), 32'(e == 12));
    end
    enable = 1'b1;

    // 5: load 7, reload 2 at edge 6, step at 10, expiry at 14.
    do_load(7, 1'b0);
    for (int e = 1; e <= 15; e++) begin
      load = (e == 6); load_value = 4'd2;
      cycle();
      if (e == 4)  check_value("t5_e4",  32'(counter_out), 6);
      if (e == 6)  check_value("t5_e6",  32'(counter_out), 2);
      if (e == 10) check_value("t5_e10", 32'(counter_out), 1);
      check_value("t5_step", 32'(step), 32'(e == 4 || e == 10 || e == 14));
      check_value("t5_term", 32'(terminal), 32'(e == 14));
    end
    load = 1'b0;

    // 6: load 0 -> idle, no terminal; load 1 on a wrap edge -> no step.
    do_load(0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_value("t6_zero_flags", {28'd0, step, terminal, done, busy}, 0);
    end
    do_load(1, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      load = (e == 4); load_value = 4'd1;
      cycle();
      check_value("t6_step", 32'(step), 32'(e == 8));
      check_value("t6_term", 32'(terminal), 32'(e == 8));
    end
    load = 1'b0;

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      load        = ($urandom_range(0, 19) == 0);
      load_value  = CW'($urandom_range(0, 15));
      enable      = ($urandom_range(0, 3) != 0);
      auto_reload = $urandom_range(0, 1) != 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
